// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master write engine.
package i2c_pkg;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } i2c_state_t;

    // Quarter-period phases of one SCL bit slot.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

    // R/W bit appended to the 7-bit address; this engine only writes.
    localparam logic ADDR_WRITE_BIT = 1'b0;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period timer for the I2C engine: divides clk by CLK_DIV into quarter
// ticks and tracks the current quarter of the bit slot. The counter is held at
// zero while disabled and frozen while hold_i is high (slave clock stretching).
// CLK_DIV must be at least 2.
module i2c_bit_timer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic     clk,
    input  logic     rst_ni,
    input  logic     enable_i,
    input  logic     hold_i,
    output logic     tick_o,
    output quarter_t phase_o
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    quarter_t         phase_q, phase_d;

    assign tick_o  = enable_i && !hold_i && (cnt_q == CNT_MAX);
    assign phase_o = phase_q;

    // Next counter / phase: clear when disabled, wrap on tick, freeze on hold.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable_i) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (tick_o) begin
            cnt_d   = '0;
            phase_d = quarter_t'(phase_q + 2'd1);
        end else if (!hold_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and phase registers with synchronous active-low reset.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_tx_engine.sv
// I2C master write engine fed by a TX fifo: START, address+W, byte_count data
// bytes MSB-first with ACK check after each, then STOP. Open-drain line
// enables, busy/done status and sticky nack/underrun errors.
// Build option: define I2C_CLOCK_STRETCH_EN to let a slave holding SCL low
// freeze the quarter timer while the engine has SCL released.
module i2c_tx_engine
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_request,
    input  logic [6:0] address,
    input  logic [3:0] byte_count,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_request,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack_error,
    output logic       underrun_error,
    input  logic       clear_error_request
);

    i2c_state_t state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bytes_q, bytes_d;
    logic       ack_q, ack_d;          // sda_in sampled in the ACK slot, 1 = NACK
    logic       nack_q, nack_d;
    logic       underrun_q, underrun_d;
    logic       done_q, done_d;

    logic       tick;
    quarter_t   phase;
    logic       q3_end;
    logic       stretch_hold;
    logic       need_byte;
    logic [3:0] remaining;

    i2c_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst_ni   (reset),
        .enable_i (state_q != ST_IDLE),
        .hold_i   (stretch_hold),
        .tick_o   (tick),
        .phase_o  (phase)
    );

    assign q3_end = tick && (phase == Q3);

`ifdef I2C_CLOCK_STRETCH_EN
    assign stretch_hold = (state_q != ST_IDLE) && !scl_oe && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stretch_hold  = 1'b0;
`endif

    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign nack_error     = nack_q;
    assign underrun_error = underrun_q;

    // Line drive decoded from state and quarter phase.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            ST_START: begin
                sda_oe = (phase != Q0);
                scl_oe = (phase == Q3);
            end
            ST_ADDR, ST_DATA: begin
                scl_oe = (phase == Q0) || (phase == Q1);
                sda_oe = !shift_q[7];
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                scl_oe = (phase == Q0) || (phase == Q1);
            end
            ST_STOP: begin
                scl_oe = (phase == Q0);
                sda_oe = (phase == Q0) || (phase == Q1);
            end
            default: ;
        endcase
    end

    // Sequencer next state, byte fetch and error flag updates.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        bytes_d         = bytes_q;
        ack_d           = ack_q;
        nack_d          = nack_q;
        underrun_d      = underrun_q;
        done_d          = 1'b0;
        fifo_rd_request = 1'b0;
        need_byte       = 1'b0;
        remaining       = bytes_q;

        if (clear_error_request) begin
            nack_d     = 1'b0;
            underrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_request) begin
                    state_d   = ST_START;
                    shift_d   = {address, ADDR_WRITE_BIT};
                    bytes_d   = byte_count;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (q3_end) state_d = ST_ADDR;
            end
            ST_ADDR, ST_DATA: begin
                if (q3_end) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
                if (tick && (phase == Q2)) ack_d = sda_in;
                if (q3_end) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        remaining = (state_q == ST_DATA_ACK) ? bytes_q - 4'd1 : bytes_q;
                        bytes_d   = remaining;
                        if (remaining == 4'd0) state_d = ST_STOP;
                        else                   need_byte = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (q3_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Fetch the next byte on the same edge that enters DATA; errors set after clear so set wins.
        if (need_byte) begin
            if (fifo_empty) begin
                underrun_d = 1'b1;
                state_d    = ST_STOP;
            end else begin
                shift_d         = fifo_rd_data;
                fifo_rd_request = 1'b1;
                state_d         = ST_DATA;
            end
        end

        if (!reset) fifo_rd_request = 1'b0;
    end

    // Sequencer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            bytes_q    <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            bytes_q    <= bytes_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_i2c_tx_engine.sv
// Self-checking bench for i2c_tx_engine: fifo model, open-drain bus, ACKing
// slave model that decodes bytes into a receive queue, and a scoreboard of
// expected bus bytes. The clock-stretch scenario runs only when
// I2C_CLOCK_STRETCH_EN is defined.
module tb_i2c_tx_engine;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CYC  = 4 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_request = 1'b0;
    logic [6:0] address = '0;
    logic [3:0] byte_count = '0;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       fifo_rd_request;
    logic       scl_in, sda_in, scl_oe, sda_oe;
    logic       busy, done, nack_error, underrun_error;
    logic       clear_error_request = 1'b0;

    always #5 clk = ~clk;

    i2c_tx_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_request       (start_request),
        .address             (address),
        .byte_count          (byte_count),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_empty          (fifo_empty),
        .fifo_rd_request     (fifo_rd_request),
        .scl_in              (scl_in),
        .sda_in              (sda_in),
        .scl_oe              (scl_oe),
        .sda_oe              (sda_oe),
        .busy                (busy),
        .done                (done),
        .nack_error          (nack_error),
        .underrun_error      (underrun_error),
        .clear_error_request (clear_error_request)
    );

    // ---------------- fifo model ----------------
    logic [7:0] fifo_mem [256];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    int         pops = 0;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_rd_request) begin
            rd_ptr <= rd_ptr + 8'd1;
            pops   <= pops + 1;
        end
    end

    task automatic fifo_push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // ---------------- open-drain bus ----------------
    logic slave_oe_q = 1'b0;
    logic stretch    = 1'b0;
    logic scl_line, sda_line;
    assign scl_line = !(scl_oe || stretch);
    assign sda_line = !(sda_oe || slave_oe_q);
    assign scl_in   = scl_line;
    assign sda_in   = sda_line;

    // ---------------- slave model / monitor ----------------
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic [7:0] sh_q = '0;
    int         bitpos_q = 0, byte_idx_q = 0;
    logic       ack_ph_q = 1'b0, do_ack_q = 1'b0;
    int         start_cnt = 0, stop_cnt = 0, done_cnt = 0, busy_cyc = 0;
    logic [7:0] nack_byte = 8'hFF;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        scl_p    <= scl_line;
        sda_p    <= sda_line;
        done_cnt <= done_cnt + int'(done);
        busy_cyc <= busy_cyc + int'(busy);
        if (scl_line && scl_p && sda_p && !sda_line) begin
            start_cnt  <= start_cnt + 1;
            bitpos_q   <= 0;
            byte_idx_q <= 0;
            ack_ph_q   <= 1'b0;
        end else if (scl_line && scl_p && !sda_p && sda_line) begin
            stop_cnt <= stop_cnt + 1;
        end else if (scl_line && !scl_p) begin
            if (ack_ph_q) begin
                ack_ph_q <= 1'b0;
            end else if (bitpos_q == 7) begin
                rx_q.push_back({sh_q[6:0], sda_line});
                do_ack_q   <= !((byte_idx_q == 0) && ({sh_q[6:0], sda_line} == nack_byte));
                ack_ph_q   <= 1'b1;
                bitpos_q   <= 0;
                byte_idx_q <= byte_idx_q + 1;
            end else begin
                sh_q     <= {sh_q[6:0], sda_line};
                bitpos_q <= bitpos_q + 1;
            end
        end else if (!scl_line && scl_p) begin
            slave_oe_q <= ack_ph_q && do_ack_q;
        end
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int passed = 0;

    task automatic kick(input logic [6:0] a, input logic [3:0] n);
        @(negedge clk);
        address       = a;
        byte_count    = n;
        start_request = 1'b1;
        @(negedge clk);
        start_request = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic sb_drain(input string tag);
        logic [7:0] e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) $display("FAIL %s_byte got=none want=%02h", tag, e);
            else begin
                g = rx_q.pop_front();
                if (g !== e) $display("FAIL %s_byte got=%02h want=%02h", tag, g, e);
                else passed++;
            end
        end
        checks++;
        if (rx_q.size() != 0) begin
            $display("FAIL %s_extra got=%0d want=0 extra bytes", tag, rx_q.size());
            rx_q.delete();
        end else passed++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (scl_oe !== 1'b0) $display("FAIL rst_scl_oe got=%b want=0", scl_oe); else passed++;
        checks++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe got=%b want=0", sda_oe); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done got=%b want=0", done); else passed++;
        checks++; if (nack_error !== 1'b0) $display("FAIL rst_nack got=%b want=0", nack_error); else passed++;
        checks++; if (underrun_error !== 1'b0) $display("FAIL rst_underrun got=%b want=0", underrun_error); else passed++;
        checks++; if (fifo_rd_request !== 1'b0) $display("FAIL rst_pop got=%b want=0", fifo_rd_request); else passed++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_bytes();
        int p0, d0, s0, st0, b0;
        bit ok;
        p0 = pops; d0 = done_cnt; s0 = stop_cnt; st0 = start_cnt; b0 = busy_cyc;
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        fifo_push(8'hA5); fifo_push(8'h3C);
        kick(7'h50, 4'd2);
        checks++; if (busy !== 1'b1) $display("FAIL wr_busy_after_accept got=%b want=1", busy); else passed++;
        wait_done(2000, ok);
        checks++; if (!ok) $display("FAIL wr_done_timeout got=no_done want=done"); else passed++;
        checks++; if (pops - p0 !== 2) $display("FAIL wr_pops got=%0d want=2", pops - p0); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL wr_done_pulses got=%0d want=1", done_cnt - d0); else passed++;
        checks++; if (start_cnt - st0 !== 1) $display("FAIL wr_starts got=%0d want=1", start_cnt - st0); else passed++;
        checks++; if (stop_cnt - s0 !== 1) $display("FAIL wr_stops got=%0d want=1", stop_cnt - s0); else passed++;
        checks++; if (busy_cyc - b0 !== BIT_CYC * 29) $display("FAIL wr_busy_cycles got=%0d want=%0d", busy_cyc - b0, BIT_CYC * 29); else passed++;
        checks++; if (nack_error !== 1'b0 || underrun_error !== 1'b0)
            $display("FAIL wr_errors got=%b%b want=00", nack_error, underrun_error); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL wr_busy_end got=%b want=0", busy); else passed++;
        sb_drain("wr");
    endtask

    task automatic test_nack();
        int p0, d0, s0, b0;
        bit ok;
        p0 = pops; d0 = done_cnt; s0 = stop_cnt; b0 = busy_cyc;
        nack_byte = 8'h42;
        exp_q.push_back(8'h42);
        kick(7'h21, 4'd2);
        wait_done(2000, ok);
        checks++; if (!ok) $display("FAIL nack_done_timeout got=no_done want=done"); else passed++;
        checks++; if (nack_error !== 1'b1) $display("FAIL nack_flag got=%b want=1", nack_error); else passed++;
        checks++; if (underrun_error !== 1'b0) $display("FAIL nack_underrun got=%b want=0", underrun_error); else passed++;
        checks++; if (pops - p0 !== 0) $display("FAIL nack_pops got=%0d want=0", pops - p0); else passed++;
        checks++; if (stop_cnt - s0 !== 1) $display("FAIL nack_stops got=%0d want=1", stop_cnt - s0); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL nack_done_pulses got=%0d want=1", done_cnt - d0); else passed++;
        checks++; if (busy_cyc - b0 !== BIT_CYC * 11) $display("FAIL nack_busy_cycles got=%0d want=%0d", busy_cyc - b0, BIT_CYC * 11); else passed++;
        sb_drain("nack");
        nack_byte = 8'hFF;
        @(negedge clk); clear_error_request = 1'b1;
        @(negedge clk); clear_error_request = 1'b0;
        checks++; if (nack_error !== 1'b0) $display("FAIL nack_clear got=%b want=0", nack_error); else passed++;
    endtask

    task automatic test_address_only_busy_ignore();
        int p0, d0, st0, b0;
        bit ok;
        p0 = pops; d0 = done_cnt; st0 = start_cnt; b0 = busy_cyc;
        exp_q.push_back(8'h24);
        kick(7'h12, 4'd0);
        repeat (20) @(negedge clk);
        kick(7'h7F, 4'd5);
        checks++; if (busy !== 1'b1) $display("FAIL ign_busy_mid got=%b want=1", busy); else passed++;
        wait_done(2000, ok);
        checks++; if (!ok) $display("FAIL ign_done_timeout got=no_done want=done"); else passed++;
        checks++; if (busy_cyc - b0 !== BIT_CYC * 11) $display("FAIL ign_busy_cycles got=%0d want=%0d", busy_cyc - b0, BIT_CYC * 11); else passed++;
        repeat (50) @(negedge clk);
        checks++; if (pops - p0 !== 0) $display("FAIL ign_pops got=%0d want=0", pops - p0); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL ign_done_pulses got=%0d want=1", done_cnt - d0); else passed++;
        checks++; if (start_cnt - st0 !== 1) $display("FAIL ign_starts got=%0d want=1", start_cnt - st0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL ign_busy_end got=%b want=0", busy); else passed++;
        checks++; if (nack_error !== 1'b0) $display("FAIL ign_nack got=%b want=0", nack_error); else passed++;
        sb_drain("ign");
    endtask

    task automatic test_underrun();
        int p0, d0, s0, b0;
        bit ok;
        p0 = pops; d0 = done_cnt; s0 = stop_cnt; b0 = busy_cyc;
        exp_q.push_back(8'h76); exp_q.push_back(8'h77);
        fifo_push(8'h77);
        kick(7'h3B, 4'd3);
        wait_done(2000, ok);
        checks++; if (!ok) $display("FAIL unr_done_timeout got=no_done want=done"); else passed++;
        checks++; if (underrun_error !== 1'b1) $display("FAIL unr_flag got=%b want=1", underrun_error); else passed++;
        checks++; if (nack_error !== 1'b0) $display("FAIL unr_nack got=%b want=0", nack_error); else passed++;
        checks++; if (pops - p0 !== 1) $display("FAIL unr_pops got=%0d want=1", pops - p0); else passed++;
        checks++; if (stop_cnt - s0 !== 1) $display("FAIL unr_stops got=%0d want=1", stop_cnt - s0); else passed++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL unr_done_pulses got=%0d want=1", done_cnt - d0); else passed++;
        checks++; if (busy_cyc - b0 !== BIT_CYC * 20) $display("FAIL unr_busy_cycles got=%0d want=%0d", busy_cyc - b0, BIT_CYC * 20); else passed++;
        sb_drain("unr");
    endtask

    task automatic test_reset_mid_data();
        int p0;
        bit hit;
        p0 = pops;
        checks++; if (underrun_error !== 1'b1) $display("FAIL mid_sticky_before got=%b want=1", underrun_error); else passed++;
        exp_q.push_back(8'hA0);
        fifo_push(8'h99);
        kick(7'h50, 4'd1);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (byte_idx_q == 1 && bitpos_q == 2) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) $display("FAIL mid_reach_data got=timeout want=data_bit2"); else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0)
            $display("FAIL mid_lines got=scl%b sda%b want=scl0 sda0", scl_oe, sda_oe); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b want=0", busy); else passed++;
        checks++; if (underrun_error !== 1'b0 || nack_error !== 1'b0)
            $display("FAIL mid_errors got=%b%b want=00", nack_error, underrun_error); else passed++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (pops - p0 !== 1) $display("FAIL mid_pops got=%0d want=1", pops - p0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_idle_after got=%b want=0", busy); else passed++;
        sb_drain("mid");
    endtask

`ifdef I2C_CLOCK_STRETCH_EN
    task automatic test_stretch();
        int b0, p0;
        bit ok, hit;
        b0 = busy_cyc; p0 = pops;
        exp_q.push_back(8'hA0); exp_q.push_back(8'hC3);
        fifo_push(8'hC3);
        kick(7'h50, 4'd1);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (byte_idx_q == 1 && bitpos_q == 3 && scl_oe) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) $display("FAIL str_reach_bit3 got=timeout want=bit3"); else passed++;
        stretch = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!scl_oe) break;
        end
        repeat (20) @(negedge clk);
        stretch = 1'b0;
        wait_done(2000, ok);
        checks++; if (!ok) $display("FAIL str_done_timeout got=no_done want=done"); else passed++;
        checks++; if (busy_cyc - b0 !== BIT_CYC * 20 + 20)
            $display("FAIL str_busy_cycles got=%0d want=%0d", busy_cyc - b0, BIT_CYC * 20 + 20); else passed++;
        checks++; if (pops - p0 !== 1) $display("FAIL str_pops got=%0d want=1", pops - p0); else passed++;
        sb_drain("str");
    endtask
`endif

    initial begin
        test_reset();
        test_write_bytes();
        test_nack();
        test_address_only_busy_ignore();
        test_underrun();
        test_reset_mid_data();
`ifdef I2C_CLOCK_STRETCH_EN
        test_stretch();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
